instruction_loader: RTL
=======================

# instruction_loader

Write-side companion to the instruction memory: accepts a program as a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and drives the memory's write port at consecutive word addresses. Holds the CPU in reset while loading and releases it once the full program is written. Sits between the host/debug byte source and the instruction memory write port, ahead of the PC/fetch path.

## Interface
- MEM_SIZE, 16: instruction memory depth in 32-bit words; maximum program length.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session (honoured in IDLE, DONE, ERROR only).
- byte_in  in  8  program/header byte.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  one-cycle write strobe to instruction memory.
- wr_adr  out  64  byte address of write; always a multiple of 4.
- wr_data  out  32  instruction to write.
- busy  out  1  session in progress (HEADER, LOAD, WRITE).
- done  out  1  program fully written.
- error  out  1  invalid header received.
- cpu_reset  out  1  hold CPU in reset; low only in DONE.

## Operation
- States: IDLE, HEADER, LOAD, WRITE, DONE, ERROR.
- Byte accepted on a rising edge where byte_valid && byte_ready.
- IDLE: byte_ready=0. start -> HEADER; clears word index, byte counter, done, error.
- HEADER: byte_ready=1. Accepted byte is N = word count. N==0 or N>MEM_SIZE -> ERROR; else latch N -> LOAD.
- LOAD: byte_ready=1. Bytes fill wr_data little-endian: byte 0 -> [7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24]. On 4th accepted byte -> WRITE.
- WRITE: byte_ready=0; wr_en=1 for exactly this cycle; wr_adr = 4*index (zero-extended to 64 bits); wr_data = assembled word. Then index+1; if index+1 == N -> DONE, else LOAD with byte counter cleared.
- DONE: done=1, cpu_reset=0, byte_ready=0. Stays until start (-> HEADER, cpu_reset back to 1) or reset.
- ERROR: error=1, cpu_reset=1, byte_ready=0. Stays until start (-> HEADER) or reset. No writes issued.
- start while busy: ignored. byte_valid in IDLE/WRITE/DONE/ERROR: ignored, byte not consumed.
- Index counter wide enough for MEM_SIZE; wr_adr never exceeds 4*(MEM_SIZE-1).

## Timing
- Reset values: byte_ready 0, wr_en 0, wr_adr 0, wr_data 0, busy 0, done 0, error 0, cpu_reset 1; state IDLE.
- All outputs registered or decoded from registered state; no combinational path byte_valid -> byte_ready.
- start in cycle t -> byte_ready=1 from t+1.
- 4th byte of a word accepted at edge t -> wr_en=1 during cycle t+1 -> byte_ready=1 again at t+2 (LOAD) or done=1 at t+2 (last word).
- Minimum session length with continuous bytes: 1 + 5*N cycles after start.
- Gaps in byte_valid stall assembly without loss; partially assembled bytes kept.
- wr_adr/wr_data hold last written values outside WRITE (wr_en=0 qualifies them).
- Reset mid-session (any state): next cycle in IDLE with reset values; partial word discarded, no wr_en issued, cpu_reset=1.

## Test plan
- Reset check: assert reset 2 cycles -> all outputs at reset values, cpu_reset=1, byte_ready=0.
- Two-word load: start, bytes 0x02, 0x78,0x56,0x34,0x12, 0xEF,0xBE,0xAD,0xDE -> wr_en pulses with (adr 0x0, data 0x12345678) then (adr 0x4, data 0xDEADBEEF); done=1, cpu_reset=0 one cycle after second write; total 11 cycles from start.
- Bad header: start, byte 0x00 -> error=1, no wr_en; start, byte 0x11 (17 > MEM_SIZE) -> error=1; start, byte 0x01 + 4 bytes -> recovers, done=1.
- Full depth with stalls: N=16, byte_valid random 50% -> 16 writes at adr 0x0..0x3C in order, data matches stream; read back via instruction memory read port matches.
- Reset mid-word: N=2, send 0x02 plus 6 bytes, assert reset -> exactly one write (adr 0x0), IDLE, cpu_reset=1; new session writes adr 0x0 again.
- Ignored inputs: start pulse during LOAD and byte_valid during WRITE/DONE -> no state change, no byte consumed, write sequence unchanged.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream program loader: takes a word-count header plus little-endian instruction bytes,
// writes them to consecutive instruction memory words and holds the CPU in reset until done.
module instruction_loader #(
    parameter int unsigned MEM_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [63:0] wr_adr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset
);

    localparam int unsigned IdxW     = $clog2(MEM_SIZE + 1);
    localparam logic [7:0]  MaxWords = 8'(MEM_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StLoad,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] count_q;
    logic [IdxW-1:0] index_q;
    logic [IdxW-1:0] index_inc;
    logic [1:0]      byte_cnt_q;
    logic [23:0]     asm_q;
    logic [63:0]     wr_adr_q;
    logic [31:0]     wr_data_q;
    logic            accept;
    logic            hdr_bad;
    logic            start_ok;

    // byte_ready is decoded from state only, so accept never loops back into it
    assign accept    = byte_valid && byte_ready;
    assign hdr_bad   = (byte_in == 8'd0) || (byte_in > MaxWords);
    assign start_ok  = start && (state_q inside {StIdle, StDone, StError});
    assign index_inc = index_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) state_d = StHeader;
            end
            StHeader: begin
                if (accept) state_d = hdr_bad ? StError : StLoad;
            end
            StLoad: begin
                if (accept && byte_cnt_q == 2'd3) state_d = StWrite;
            end
            StWrite: begin
                state_d = (index_inc == count_q) ? StDone : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        unique case (state_q)
            StHeader, StLoad: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            StWrite: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StError: error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wr_adr_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            if (start_ok) begin
                index_q    <= '0;
                byte_cnt_q <= '0;
            end
            if (state_q == StHeader && accept && !hdr_bad) begin
                count_q <= byte_in[IdxW-1:0];
            end
            if (state_q == StLoad && accept) begin
                // counter wraps to zero after the fourth byte, ready for the next word
                byte_cnt_q <= byte_cnt_q + 1'b1;
                case (byte_cnt_q)
                    2'd0: asm_q[7:0]   <= byte_in;
                    2'd1: asm_q[15:8]  <= byte_in;
                    2'd2: asm_q[23:16] <= byte_in;
                    default: begin
                        wr_data_q <= {byte_in, asm_q};
                        wr_adr_q  <= {{(62 - IdxW){1'b0}}, index_q, 2'b00};
                    end
                endcase
            end
            if (state_q == StWrite) begin
                index_q <= index_inc;
            end
        end
    end

    assign wr_adr  = wr_adr_q;
    assign wr_data = wr_data_q;

endmodule
